// File: rtl/mem_arbiter.sv
// Three-way arbiter (fetch, load/store, debug) in front of a single-port synchronous memory.
// Optional build macro MEM_ARB_RR_EN selects rotating priority instead of fixed dbg > dm > if.
module mem_arbiter #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_gnt,
   output logic          dbg_rvalid,
   input  logic          dbg_lock,
   output logic [DW-1:0] rdata,
   output logic          cpu_stall,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic {RUN, LOCKED} state_t;
   typedef enum logic [1:0] {RESP_NONE, RESP_IF, RESP_DM, RESP_DBG} resp_t;

   state_t     state, state_nxt;
   resp_t      resp_id, resp_nxt;
   logic       cpu_mask;
   logic [2:0] elig;  // {dbg, dm, if}
   logic [2:0] gnt;

   assign cpu_mask = dbg_lock | (state == LOCKED);
   assign elig     = rst_n ? {dbg_req, dm_req & ~cpu_mask, if_req & ~cpu_mask} : 3'b000;

`ifdef MEM_ARB_RR_EN
   logic [1:0] ptr, ptr_nxt;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      gnt = 3'b000;
      case (ptr)
         2'd1: begin
            if      (elig[1]) gnt = 3'b010;
            else if (elig[2]) gnt = 3'b100;
            else if (elig[0]) gnt = 3'b001;
         end
         2'd2: begin
            if      (elig[2]) gnt = 3'b100;
            else if (elig[0]) gnt = 3'b001;
            else if (elig[1]) gnt = 3'b010;
         end
         default: begin
            if      (elig[0]) gnt = 3'b001;
            else if (elig[1]) gnt = 3'b010;
            else if (elig[2]) gnt = 3'b100;
         end
      endcase
   end

   // Pointer moves to the port after the winner and holds on idle cycles.
   always_comb begin
      ptr_nxt = ptr;
      if      (gnt[0]) ptr_nxt = 2'd1;
      else if (gnt[1]) ptr_nxt = 2'd2;
      else if (gnt[2]) ptr_nxt = 2'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr <= 2'd0;
      else        ptr <= ptr_nxt;
   end
`else
   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      gnt = 3'b000;
      if      (elig[2]) gnt = 3'b100;
      else if (elig[1]) gnt = 3'b010;
      else if (elig[0]) gnt = 3'b001;
   end
`endif

   assign if_gnt  = gnt[0];
   assign dm_gnt  = gnt[1];
   assign dbg_gnt = gnt[2];

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      resp_nxt  = RESP_NONE;
      if (gnt[2]) begin
         mem_en    = 1'b1;
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
         resp_nxt  = dbg_we ? RESP_NONE : RESP_DBG;
      end else if (gnt[1]) begin
         mem_en    = 1'b1;
         mem_we    = dm_we;
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
         resp_nxt  = dm_we ? RESP_NONE : RESP_DM;
      end else if (gnt[0]) begin
         mem_en    = 1'b1;
         mem_addr  = if_addr;
         resp_nxt  = RESP_IF;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (dbg_lock)  state_nxt = LOCKED;
         LOCKED:  if (!dbg_lock) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RUN;
         resp_id <= RESP_NONE;
      end else begin
         state   <= state_nxt;
         resp_id <= resp_nxt;
      end
   end

   assign cpu_stall  = (state == LOCKED);
   assign if_rvalid  = (resp_id == RESP_IF);
   assign dm_rvalid  = (resp_id == RESP_DM);
   assign dbg_rvalid = (resp_id == RESP_DBG);
   assign rdata      = (resp_id != RESP_NONE) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, reset/lock corner sequences,
// and randomized traffic checked against a priority-list reference model.
module tb_mem_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req, if_gnt, if_rvalid;
   logic [AW-1:0] if_addr;
   logic          dm_req, dm_we, dm_gnt, dm_rvalid;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic          dbg_lock;
   logic [DW-1:0] rdata;
   logic          cpu_stall;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
      .dbg_lock(dbg_lock), .rdata(rdata), .cpu_stall(cpu_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Synchronous single-port memory, 1-cycle read latency.
   logic [DW-1:0] mem_array [1024];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem_array[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem_array[mem_addr];
      end
   end

   // Reference model: ports 0=if, 1=dm, 2=dbg; a priority list picks the winner.
   logic [DW-1:0] shadow [1024];
   bit            m_locked;
   int            m_pend;
   logic [DW-1:0] m_pdata;
   int            m_ptr;
   int            mw;

   function automatic int exp_winner();
      bit el [3];
      int p;
      if (rst_n !== 1'b1) return -1;
      el[0] = if_req && !dbg_lock && !m_locked;
      el[1] = dm_req && !dbg_lock && !m_locked;
      el[2] = dbg_req;
      for (int k = 0; k < 3; k++) begin
`ifdef MEM_ARB_RR_EN
         p = (m_ptr + k) % 3;
`else
         p = 2 - k;
`endif
         if (el[p]) return p;
      end
      return -1;
   endfunction

   function automatic bit win_we(input int w);
      case (w)
         1:       return dm_we;
         2:       return dbg_we;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [AW-1:0] win_addr(input int w);
      case (w)
         0:       return if_addr;
         1:       return dm_addr;
         2:       return dbg_addr;
         default: return '0;
      endcase
   endfunction

   function automatic logic [DW-1:0] win_wdata(input int w);
      case (w)
         1:       return dm_wdata;
         2:       return dbg_wdata;
         default: return '0;
      endcase
   endfunction

   always_comb mw = exp_winner();

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_locked <= 1'b0;
         m_pend   <= -1;
         m_pdata  <= '0;
         m_ptr    <= 0;
      end else begin
         m_locked <= dbg_lock;
         m_pend   <= (mw >= 0 && !win_we(mw)) ? mw : -1;
         m_pdata  <= shadow[win_addr(mw)];
         if (mw >= 0 && win_we(mw)) shadow[win_addr(mw)] <= win_wdata(mw);
         if (mw >= 0) m_ptr <= (mw + 1) % 3;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      int w;
      w = mw;
      check("gnt",       32'({dbg_gnt, dm_gnt, if_gnt}), (w < 0) ? 32'd0 : 32'(1 << w));
      check("mem_en",    32'(mem_en),    32'(w >= 0));
      check("mem_we",    32'(mem_we),    (w >= 0) ? 32'(win_we(w)) : 32'd0);
      check("mem_addr",  32'(mem_addr),  32'(win_addr(w)));
      check("mem_wdata", mem_wdata,      win_wdata(w));
      check("rvalid",    32'({dbg_rvalid, dm_rvalid, if_rvalid}),
            (m_pend < 0) ? 32'd0 : 32'(1 << m_pend));
      check("rdata",     rdata,          (m_pend < 0) ? 32'd0 : m_pdata);
      check("cpu_stall", 32'(cpu_stall), 32'(m_locked));
   endtask

   typedef struct {
      logic          if_req;
      logic [AW-1:0] if_addr;
      logic          dm_req;
      logic          dm_we;
      logic [AW-1:0] dm_addr;
      logic [DW-1:0] dm_wdata;
      logic          dbg_req;
      logic          dbg_we;
      logic [AW-1:0] dbg_addr;
      logic [DW-1:0] dbg_wdata;
      logic          dbg_lock;
   } stim_t;

   typedef struct {
      stim_t         s;
      logic [2:0]    gnt;     // {dbg, dm, if}
      logic [2:0]    rvalid;  // {dbg, dm, if}
      logic          stall;
      logic          chk_rdata;
      logic [DW-1:0] rdata;
   } vec_t;

   function automatic stim_t mk(input bit ir, input int ia, input bit dr, input bit dw, input int da,
                                input logic [DW-1:0] dd, input bit br, input bit bw, input int ba,
                                input logic [DW-1:0] bd, input bit lk);
      stim_t s;
      s.if_req = ir;  s.if_addr = AW'(ia);
      s.dm_req = dr;  s.dm_we = dw;  s.dm_addr = AW'(da);  s.dm_wdata = dd;
      s.dbg_req = br; s.dbg_we = bw; s.dbg_addr = AW'(ba); s.dbg_wdata = bd;
      s.dbg_lock = lk;
      return s;
   endfunction

   function automatic vec_t mv(input stim_t s, input logic [2:0] g, input logic [2:0] rv,
                               input logic st, input logic cr, input logic [DW-1:0] rd);
      vec_t v;
      v.s = s; v.gnt = g; v.rvalid = rv; v.stall = st; v.chk_rdata = cr; v.rdata = rd;
      return v;
   endfunction

   task automatic drive(input stim_t s);
      if_req   = s.if_req;   if_addr   = s.if_addr;
      dm_req   = s.dm_req;   dm_we     = s.dm_we;    dm_addr  = s.dm_addr;  dm_wdata  = s.dm_wdata;
      dbg_req  = s.dbg_req;  dbg_we    = s.dbg_we;   dbg_addr = s.dbg_addr; dbg_wdata = s.dbg_wdata;
      dbg_lock = s.dbg_lock;
   endtask

   task automatic apply(input stim_t s);
      @(negedge clk);
      drive(s);
      #1;
      model_check();
   endtask

`ifdef MEM_ARB_RR_EN
   localparam logic [2:0] REL_GNT = 3'b001;
`else
   localparam logic [2:0] REL_GNT = 3'b100;
`endif

   stim_t idle, all3, s;
   vec_t  tbl [$];
   bit    lk;

   initial begin
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      all3 = mk(1, 4, 1, 0, 3, 32'h0, 1, 0, 3, 32'h0, 0);
      for (int i = 0; i < 1024; i++) begin
         mem_array[i] = $urandom;
         shadow[i]    = mem_array[i];
      end
      mem_array[0] = 32'h0000_0013; shadow[0] = 32'h0000_0013;
      mem_array[5] = 32'h0001_F0B7; shadow[5] = 32'h0001_F0B7;
      mem_array[7] = 32'hCAFE_0007; shadow[7] = 32'hCAFE_0007;

      // Reset held with every request active: nothing may be granted.
      rst_n = 1'b0;
      drive(all3);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_gnt",    32'({dbg_gnt, dm_gnt, if_gnt}), 32'd0);
      check("rst_stall",  32'(cpu_stall), 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_rvalid", 32'({dbg_rvalid, dm_rvalid, if_rvalid}), 32'd0);
      check("rst_rdata",  rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("release_gnt", 32'({dbg_gnt, dm_gnt, if_gnt}), 32'(REL_GNT));
      model_check();

`ifndef MEM_ARB_RR_EN
      //        if  ia  dm dw da  dd             dbg bw ba  bd             lk
      tbl.push_back(mv(idle,                                                          3'b000, 3'b100, 0, 0, 0));
      tbl.push_back(mv(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0),                           3'b001, 3'b000, 0, 0, 0));
      tbl.push_back(mv(idle,                                                          3'b000, 3'b001, 0, 1, 32'h0001_F0B7));
      tbl.push_back(mv(mk(1, 0, 1, 0, 7, 0, 0, 0, 0, 0, 0),                           3'b010, 3'b000, 0, 0, 0));
      tbl.push_back(mv(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),                           3'b001, 3'b010, 0, 1, 32'hCAFE_0007));
      tbl.push_back(mv(idle,                                                          3'b000, 3'b001, 0, 1, 32'h0000_0013));
      tbl.push_back(mv(mk(1, 1, 0, 0, 0, 0, 1, 1, 1, 32'h000F_1137, 1),               3'b100, 3'b000, 0, 0, 0));
      tbl.push_back(mv(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1),                           3'b000, 3'b000, 1, 0, 0));
      tbl.push_back(mv(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0),                           3'b000, 3'b000, 1, 0, 0));
      tbl.push_back(mv(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0),                           3'b001, 3'b000, 0, 0, 0));
      tbl.push_back(mv(idle,                                                          3'b000, 3'b001, 0, 1, 32'h000F_1137));
      tbl.push_back(mv(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),                           3'b001, 3'b000, 0, 0, 0));
      tbl.push_back(mv(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),                           3'b000, 3'b001, 0, 1, 32'h0000_0013));
      tbl.push_back(mv(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1),                           3'b100, 3'b000, 1, 0, 0));
      tbl.push_back(mv(idle,                                                          3'b000, 3'b100, 1, 1, 32'h000F_1137));
      tbl.push_back(mv(idle,                                                          3'b000, 3'b000, 0, 0, 0));
      tbl.push_back(mv(mk(0, 0, 1, 1, 9, 32'h1234_5678, 0, 0, 0, 0, 0),               3'b010, 3'b000, 0, 0, 0));
      tbl.push_back(mv(mk(0, 0, 1, 0, 9, 0, 0, 0, 0, 0, 0),                           3'b010, 3'b000, 0, 0, 0));
      tbl.push_back(mv(idle,                                                          3'b000, 3'b010, 0, 1, 32'h1234_5678));
      tbl.push_back(mv(mk(1, 4, 1, 0, 3, 0, 1, 0, 2, 0, 0),                           3'b100, 3'b000, 0, 0, 0));
      tbl.push_back(mv(idle,                                                          3'b000, 3'b100, 0, 0, 0));
      foreach (tbl[i]) begin
         apply(tbl[i].s);
         check($sformatf("vec%0d_gnt", i),    32'({dbg_gnt, dm_gnt, if_gnt}), 32'(tbl[i].gnt));
         check($sformatf("vec%0d_rvalid", i), 32'({dbg_rvalid, dm_rvalid, if_rvalid}), 32'(tbl[i].rvalid));
         check($sformatf("vec%0d_stall", i),  32'(cpu_stall), 32'(tbl[i].stall));
         if (tbl[i].chk_rdata) check($sformatf("vec%0d_rdata", i), rdata, tbl[i].rdata);
      end
`endif

      // Reset while a read response is pending: it is dropped and never reappears.
      apply(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      apply(mk(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      check("pend_rvalid", 32'({dbg_rvalid, dm_rvalid, if_rvalid}), 32'b001);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_rvalid", 32'({dbg_rvalid, dm_rvalid, if_rvalid}), 32'd0);
      check("midrst_gnt",    32'({dbg_gnt, dm_gnt, if_gnt}), 32'd0);
      @(negedge clk);
      drive(idle);
      rst_n = 1'b1;
      #1;
      check("postrst_rvalid", 32'({dbg_rvalid, dm_rvalid, if_rvalid}), 32'd0);
      apply(idle);
      check("postrst_rvalid2", 32'({dbg_rvalid, dm_rvalid, if_rvalid}), 32'd0);

      // Randomized traffic against the reference model.
      lk = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 7) == 0) lk = !lk;
         s = mk($urandom_range(0, 1), $urandom_range(0, 15),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15), $urandom,
                ($urandom_range(0, 2) == 0), $urandom_range(0, 1), $urandom_range(0, 15), $urandom,
                lk);
         apply(s);
      end
      apply(idle);
      apply(idle);

`ifdef MEM_ARB_RR_EN
      // Rotating priority: all three held from reset grant in strict rotation.
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         logic [2:0] exp_rr;
         exp_rr = (i % 3 == 0) ? 3'b001 : ((i % 3 == 1) ? 3'b010 : 3'b100);
         apply(all3);
         check($sformatf("rr%0d_gnt", i), 32'({dbg_gnt, dm_gnt, if_gnt}), 32'(exp_rr));
      end
      apply(idle);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
